// File: rtl/ibram_pingpong_writer_if.sv
// Write-side and reader-side bundle of the IBRAM ping/pong writer.
// master = upstream controller / reader side, slave = the writer itself.
interface ibram_pingpong_writer_if #(
  parameter int STREAM_WIDTH = 128,
  parameter int NUM_BANKS    = 16,
  parameter int BUF_DEPTH    = 64,
  parameter int ADDR_W       = $clog2(2*BUF_DEPTH),
  parameter int LEN_W        = $clog2(BUF_DEPTH+1)
);
  logic [NUM_BANKS-1:0][STREAM_WIDTH-1:0] wr_data;
  logic [NUM_BANKS-1:0]                   wr_en;
  logic [NUM_BANKS-1:0]                   wr_we;
  logic                                   wr_done;
  logic [NUM_BANKS-1:0]                   full;
  logic [NUM_BANKS-1:0][ADDR_W-1:0]       bram_addr;
  logic [NUM_BANKS-1:0][STREAM_WIDTH-1:0] bram_din;
  logic [NUM_BANKS-1:0]                   bram_we;
  logic                                   rd_buf_valid;
  logic                                   rd_buf_sel;
  logic [NUM_BANKS-1:0][LEN_W-1:0]        rd_buf_len;
  logic                                   rd_release;
  logic                                   err_overflow;

  modport master (
    output wr_data, wr_en, wr_we, wr_done, rd_release,
    input  full, bram_addr, bram_din, bram_we,
    input  rd_buf_valid, rd_buf_sel, rd_buf_len, err_overflow
  );

  modport slave (
    input  wr_data, wr_en, wr_we, wr_done, rd_release,
    output full, bram_addr, bram_din, bram_we,
    output rd_buf_valid, rd_buf_sel, rd_buf_len, err_overflow
  );
endinterface

// File: rtl/ibram_pingpong_writer.sv
// Ping/pong IBRAM writer: registers controller writes into the owned half
// and hands completed halves to the compute-side reader.
module ibram_pingpong_writer #(
  parameter int STREAM_WIDTH = 128,
  parameter int NUM_BANKS    = 16,
  parameter int BUF_DEPTH    = 64,
  parameter int ADDR_W       = $clog2(2*BUF_DEPTH),
  parameter int LEN_W        = $clog2(BUF_DEPTH+1)
) (
  input logic clk,
  input logic rst_n,
  ibram_pingpong_writer_if.slave bus
);

  localparam logic [0:0] W_FILL = 1'b0;
  localparam logic [0:0] W_WAIT = 1'b1;
  localparam logic [LEN_W-1:0] DEPTH = LEN_W'(BUF_DEPTH);

  logic [0:0] state_q, state_d;
  logic       wsel_q, wsel_d;

  logic [NUM_BANKS-1:0][LEN_W-1:0] wptr_q;
  logic [NUM_BANKS-1:0][LEN_W-1:0] wptr_d;
  logic [NUM_BANKS-1:0][LEN_W-1:0] wptr_inc;

  logic [NUM_BANKS-1:0] full_q, full_d;
  logic [NUM_BANKS-1:0] acc;
  logic [NUM_BANKS-1:0] we_q;

  logic [NUM_BANKS-1:0][ADDR_W-1:0]       addr_q;
  logic [NUM_BANKS-1:0][STREAM_WIDTH-1:0] din_q;

  logic rd_valid_q, rd_valid_d;
  logic rd_sel_q, rd_sel_d;
  logic [NUM_BANKS-1:0][LEN_W-1:0] rd_len_q;
  logic [NUM_BANKS-1:0][LEN_W-1:0] rd_len_d;

  logic err_q;
  logic ovf;
  logic rel_ok;
  logic publish;
  logic stall;

  always_comb begin
    acc    = bus.wr_en & bus.wr_we & ~full_q;
    ovf    = |(bus.wr_en & bus.wr_we & full_q);
    rel_ok = bus.rd_release & rd_valid_q;
    for (int i = 0; i < NUM_BANKS; i++) begin
      wptr_inc[i] = wptr_q[i] + LEN_W'(acc[i]);
    end
  end

  // The only half that can be READY is the one the writer does not own,
  // so "other half free" reduces to: nothing ready, or it is released now.
  always_comb begin
    publish = 1'b0;
    stall   = 1'b0;
    if (state_q == W_FILL) begin
      publish = bus.wr_done & (~rd_valid_q | rel_ok);
      stall   = bus.wr_done & rd_valid_q & ~bus.rd_release;
    end else begin
      publish = rel_ok;
    end
  end

  always_comb begin
    state_d    = state_q;
    wsel_d     = wsel_q;
    wptr_d     = wptr_inc;
    rd_valid_d = rd_valid_q & ~rel_ok;
    rd_sel_d   = rd_sel_q;
    rd_len_d   = rd_len_q;
    for (int i = 0; i < NUM_BANKS; i++) begin
      full_d[i] = (wptr_inc[i] == DEPTH) | (state_q == W_WAIT);
    end
    unique case (1'b1)
      publish: begin
        state_d    = W_FILL;
        wsel_d     = ~wsel_q;
        wptr_d     = '0;
        full_d     = '0;
        rd_valid_d = 1'b1;
        rd_sel_d   = wsel_q;
        rd_len_d   = wptr_inc;
      end
      stall: begin
        state_d = W_WAIT;
        full_d  = '1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= W_FILL;
      wsel_q     <= 1'b0;
      wptr_q     <= '0;
      full_q     <= '0;
      we_q       <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_sel_q   <= 1'b0;
      rd_len_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wsel_q     <= wsel_d;
      wptr_q     <= wptr_d;
      full_q     <= full_d;
      we_q       <= acc;
      rd_valid_q <= rd_valid_d;
      rd_sel_q   <= rd_sel_d;
      rd_len_q   <= rd_len_d;
      if (ovf) err_q <= 1'b1;
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (acc[i]) begin
          addr_q[i] <= {wsel_q, wptr_q[i][ADDR_W-2:0]};
          din_q[i]  <= bus.wr_data[i];
        end
      end
    end
  end

  assign bus.full         = full_q;
  assign bus.bram_we      = we_q;
  assign bus.bram_addr    = addr_q;
  assign bus.bram_din     = din_q;
  assign bus.rd_buf_valid = rd_valid_q;
  assign bus.rd_buf_sel   = rd_sel_q;
  assign bus.rd_buf_len   = rd_len_q;
  assign bus.err_overflow = err_q;

endmodule

// File: tb/tb_ibram_pingpong_writer.sv
// Scoreboard bench for ibram_pingpong_writer: directed scenarios then
// random traffic, checked against a buffer-ownership reference model.
module tb_ibram_pingpong_writer;

  localparam int W  = 128;
  localparam int NB = 16;
  localparam int D  = 64;
  localparam int AW = $clog2(2*D);
  localparam int LW = $clog2(D+1);

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wr_t;

  typedef struct {
    bit                   sel;
    logic [NB-1:0][LW-1:0] lens;
  } pub_t;

  typedef struct {
    logic [NB-1:0] full;
    logic          err;
    logic          valid;
    logic [NB-1:0] we;
    bit            rst;
  } cyc_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ibram_pingpong_writer_if bus();

  ibram_pingpong_writer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  wr_t  wq[NB][$];
  pub_t pq[$];
  cyc_t cq[$];

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model: what each half holds and who owns it
  int fill[NB];
  bit cur;
  bit waiting;
  bit have_ready;
  bit m_err;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step(input logic [NB-1:0] en, input logic [NB-1:0] we,
                      input logic [NB-1:0][W-1:0] d, input bit done,
                      input bit rel, input bit rst);
    cyc_t c;
    pub_t p;
    wr_t  w;
    bit   rel_ok;
    bit   do_pub;
    @(negedge clk);
    bus.wr_en      = en;
    bus.wr_we      = we;
    bus.wr_data    = d;
    bus.wr_done    = done;
    bus.rd_release = rel;
    rst_n          = !rst;
    c.rst = rst;
    c.we  = '0;
    if (rst) begin
      for (int i = 0; i < NB; i++) fill[i] = 0;
      cur = 0; waiting = 0; have_ready = 0; m_err = 0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (en[i] && we[i]) begin
          if (waiting || fill[i] == D) begin
            m_err = 1;
          end else begin
            w.addr = AW'(cur * D + fill[i]);
            w.data = d[i];
            wq[i].push_back(w);
            fill[i]++;
            c.we[i] = 1'b1;
          end
        end
      end
      rel_ok = rel && have_ready;
      do_pub = 0;
      if (waiting) do_pub = rel_ok;
      else if (done) begin
        if (!have_ready || rel_ok) do_pub = 1;
        else waiting = 1;
      end
      if (do_pub) begin
        p.sel = cur;
        for (int i = 0; i < NB; i++) p.lens[i] = LW'(fill[i]);
        pq.push_back(p);
        have_ready = 1;
        cur = !cur;
        waiting = 0;
        for (int i = 0; i < NB; i++) fill[i] = 0;
      end else if (rel_ok) begin
        have_ready = 0;
      end
    end
    for (int i = 0; i < NB; i++) c.full[i] = waiting || fill[i] == D;
    c.err   = m_err;
    c.valid = have_ready;
    cq.push_back(c);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, '0, 0, 0, 0);
  endtask

  task automatic wr1(input int b, input logic [W-1:0] v, input bit done,
                     input bit rel);
    logic [NB-1:0][W-1:0] dv;
    logic [NB-1:0] m;
    dv = '0;
    dv[b] = v;
    m = '0;
    m[b] = 1'b1;
    step(m, m, dv, done, rel, 0);
  endtask

  // monitor: pops expectations as the DUT presents results
  bit prev_v = 0;
  bit prev_s = 0;
  initial begin
    cyc_t c;
    wr_t  w;
    pub_t p;
    forever begin
      @(posedge clk);
      #1;
      if (cq.size() != 0) begin
        c = cq.pop_front();
        chk("full", 128'(bus.full), 128'(c.full));
        chk("err_overflow", 128'(bus.err_overflow), 128'(c.err));
        chk("rd_buf_valid", 128'(bus.rd_buf_valid), 128'(c.valid));
        chk("bram_we", 128'(bus.bram_we), 128'(c.we));
        if (c.rst) begin
          chk("rst_addr", 128'(bus.bram_addr), 128'd0);
          chk("rst_din", 128'(bus.bram_din[0]), 128'd0);
          chk("rst_len", 128'(bus.rd_buf_len), 128'd0);
          chk("rst_sel", 128'(bus.rd_buf_sel), 128'd0);
        end
        for (int i = 0; i < NB; i++) begin
          if (bus.bram_we[i] === 1'b1) begin
            if (wq[i].size() == 0) begin
              chk("unexpected_write", 128'(i), 128'hFFFF);
            end else begin
              w = wq[i].pop_front();
              chk("bram_addr", 128'(bus.bram_addr[i]), 128'(w.addr));
              chk("bram_din", bus.bram_din[i], w.data);
            end
          end
        end
        if (bus.rd_buf_valid === 1'b1 &&
            (!prev_v || bus.rd_buf_sel !== prev_s)) begin
          if (pq.size() == 0) begin
            chk("unexpected_publish", 128'(bus.rd_buf_sel), 128'hFFFF);
          end else begin
            p = pq.pop_front();
            chk("rd_buf_sel", 128'(bus.rd_buf_sel), 128'(p.sel));
            chk("rd_buf_len", 128'(bus.rd_buf_len), 128'(p.lens));
          end
        end
        prev_v = bus.rd_buf_valid;
        prev_s = bus.rd_buf_sel;
      end
    end
  end

  initial begin
    logic [NB-1:0]        en, we;
    logic [NB-1:0][W-1:0] dv;
    bus.wr_en      = '0;
    bus.wr_we      = '0;
    bus.wr_data    = '0;
    bus.wr_done    = 1'b0;
    bus.rd_release = 1'b0;

    for (int k = 0; k < 3; k++) step('0, '0, '0, 0, 0, 1);

    // three writes then publish on the fourth
    for (int k = 0; k < 3; k++) wr1(0, W'(8'hA0 + k), 0, 0);
    wr1(0, W'(8'hA3), 1, 0);
    wr1(0, W'(8'hB0), 0, 0);
    idle(1);

    // bank 5 to its limit, plus one dropped write
    for (int k = 0; k < D + 1; k++) wr1(5, rnd_word(), 0, 0);
    idle(1);

    // reader stall: done while ping still held
    step('0, '0, '0, 1, 0, 0);
    for (int k = 0; k < 10; k++) wr1(3, rnd_word(), 0, 0);
    step('0, '0, '0, 0, 1, 0);
    wr1(2, rnd_word(), 0, 0);
    wr1(2, rnd_word(), 0, 0);

    // done and release together
    wr1(7, rnd_word(), 1, 1);
    idle(2);

    // reset mid-layer with ping ready
    for (int k = 0; k < 10; k++) wr1(k % NB, rnd_word(), 0, 0);
    step('0, '0, '0, 0, 0, 1);
    wr1(0, rnd_word(), 0, 0);
    idle(2);

    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < NB; i++) begin
        en[i] = ($urandom_range(0, 9) < 7);
        we[i] = ($urandom_range(0, 9) < 9);
        dv[i] = rnd_word();
      end
      step(en, we, dv,
           $urandom_range(0, 79) == 0,
           $urandom_range(0, 59) == 0,
           $urandom_range(0, 799) == 0);
    end
    idle(3);
    @(posedge clk);
    #2;

    chk("cycle_queue_drained", 128'(cq.size()), 128'd0);
    chk("publish_queue_drained", 128'(pq.size()), 128'd0);
    for (int i = 0; i < NB; i++) begin
      chk("write_queue_drained", 128'(wq[i].size()), 128'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ibram_pingpong_writer.md
Name: ibram_pingpong_writer

Overview:
- Sits directly downstream of the accumulator-side IBRAM write controller (iwrite_controller2). Consumes its per-bank write strobes and data (doA2/enaA2/weA2) and its end-of-layer pulse (wr_done2).
- Drives the per-bank IBRAM write ports. Each bank is split into two halves (ping/pong) that alternate between the writer and the compute-side reader.
- Returns per-bank `full` backpressure (feeds full2 upstream) and publishes filled buffers to the reader through a valid/release handshake.

Parameters:
- STREAM_WIDTH, 128, write data width per bank.
- NUM_BANKS, 16, number of IBRAM banks.
- BUF_DEPTH, 64, words per half-buffer; must be a power of 2.
- ADDR_W, $clog2(2*BUF_DEPTH), BRAM write address width (MSB = half select).
- LEN_W, $clog2(BUF_DEPTH+1), buffer fill-count width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- wr_data  in  [NUM_BANKS][STREAM_WIDTH]  write data from controller (doA2).
- wr_en  in  [NUM_BANKS]  bank enable (enaA2).
- wr_we  in  [NUM_BANKS]  write enable (weA2).
- wr_done  in  1  single-cycle end-of-layer pulse (wr_done2).
- full  out  [NUM_BANKS]  per-bank backpressure to controller (full2).
- bram_addr  out  [NUM_BANKS][ADDR_W]  IBRAM port-A address.
- bram_din  out  [NUM_BANKS][STREAM_WIDTH]  IBRAM port-A data.
- bram_we  out  [NUM_BANKS]  IBRAM port-A write strobe.
- rd_buf_valid  out  1  a filled half is ready for compute.
- rd_buf_sel  out  1  which half is ready (0=ping, 1=pong).
- rd_buf_len  out  [NUM_BANKS][LEN_W]  words written per bank in the ready half.
- rd_release  in  1  single-cycle pulse: reader finished with rd_buf_sel half.
- err_overflow  out  1  sticky: a write arrived while its bank was full.

Behaviour:
- **Reset** (rst_n=0 at clk edge):
  - State W_FILL, wsel=0, all wptr=0.
  - Both halves FREE, rd_buf_valid=0, rd_buf_sel=0, rd_buf_len=0.
  - bram_we=0, bram_addr=0, bram_din=0, full=0, err_overflow=0.
  - Reset mid-operation discards all buffer contents and ownership.
- **Write accept:** for bank i, accept when wr_en[i] & wr_we[i] & !full[i].
- **Write latency:** accepted write is registered, so 1-cycle latency to the BRAM.
  - Next cycle: bram_we[i]=1, bram_addr[i]={wsel, wptr[i]}, bram_din[i]=wr_data[i].
  - Then wptr[i] increments.
  - Non-accepted cycles: bram_we[i]=0; addr/din hold their previous values.
- **Full:**
  - full[i]=1 (registered) when wptr[i]==BUF_DEPTH, or when state is W_WAIT.
  - A write with wr_en & wr_we while full[i]=1 is dropped and sets err_overflow. err_overflow clears only on reset.
- **State W_FILL:** writer owns half wsel.
  - On wr_done, if the other half is FREE (including freed by rd_release in the same cycle):
    - mark half wsel READY and latch rd_buf_len[i]=wptr[i], including any write accepted in the wr_done cycle;
    - toggle wsel, clear all wptr;
    - stay in W_FILL.
  - On wr_done while the other half is READY: go to W_WAIT.
- **State W_WAIT:** current half is complete but cannot be published.
  - All full=1; wptr is frozen.
  - On rd_release: publish the current half exactly as above (READY, latch lengths, toggle wsel, clear wptr) and return to W_FILL. full deasserts the cycle after.
  - A wr_done received in W_WAIT is ignored.
- **Reader side:**
  - rd_buf_valid=1 iff a half is READY; rd_buf_sel names it. At most one half is READY at any time.
  - rd_buf_valid, rd_buf_sel and rd_buf_len update one cycle after the publishing wr_done or rd_release.
  - rd_release with rd_buf_valid=1 frees that half; rd_buf_valid drops the next cycle unless a new half is published the same cycle.
  - rd_release with rd_buf_valid=0 is ignored.
- **Empty layer:** wr_done with no writes still publishes, with rd_buf_len=0 for all banks.
- **Wrap:** wptr saturates at BUF_DEPTH and never wraps into the other half.

Test Plan:
1. **Reset values:** reset, then write 3 words to bank 0 at data 0xA0..0xA2 -> bram_addr 0,1,2 with bram_we one cycle after each; full=0; rd_buf_valid=0.
2. **Publish and swap:** continuing scenario 1, pulse wr_done in the same cycle as a 4th write -> next cycle rd_buf_valid=1, rd_buf_sel=0, rd_buf_len[0]=4, other banks 0; the next write to bank 0 goes to address BUF_DEPTH (64).
3. **Fill to limit:** write 64 words to bank 5 -> full[5]=1 after the 64th; a 65th write is dropped, err_overflow=1, no bram_we, other banks' full=0.
4. **Reader stall:** with ping READY and unreleased, fill pong and pulse wr_done -> W_WAIT, all full=1. Pulse rd_release 10 cycles later -> rd_buf_sel=1 published, full=0 the cycle after, next writes target half 0.
5. **Simultaneous release and done:** wr_done and rd_release in the same cycle -> no W_WAIT entry, immediate swap, rd_buf_valid stays 1 with rd_buf_sel flipped.
6. **Reset mid-layer:** assert rst_n=0 with 10 words written and ping READY -> all outputs return to reset values, and the next write lands at address 0.
